multicycle_control: RTL and testbench

- Main control FSM for the multicycle RV32I subset datapath.
- Sits directly upstream of the ALU-control decoder: drives its 2-bit ALUOp, plus every datapath strobe and mux select for PC, instruction register, memory and register file.
- Handles variable-latency memory through a mem_ready handshake.
- Counts retired instructions and halts on an unsupported opcode.

---
 rtl/multicycle_control.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle RV32I-subset datapath.
// Produces every datapath strobe, mux select and the 2-bit ALUOp from the
// current state, stretches memory states on mem_ready, counts retired
// instructions and parks in a sticky halt state on an unsupported opcode.

module multicycle_control #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             OldPCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic [1:0]       MemtoReg,
  output logic [1:0]       ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret,
  output logic             halted
);

  // Supported major opcodes.
  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpReg   = 7'b0110011;
  localparam logic [6:0] OpImm   = 7'b0010011;
  localparam logic [6:0] OpBeq   = 7'b1100011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpJalr  = 7'b1100111;
  localparam logic [6:0] OpLui   = 7'b0110111;

  // Encodings are visible on the debug state port, so they are pinned.
  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAdr  = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExR     = 4'd6,
    StExI     = 4'd7,
    StAluWb   = 4'd8,
    StBeq     = 4'd9,
    StJal     = 4'd10,
    StJalr    = 4'd11,
    StLui     = 4'd12,
    StIllegal = 4'd15
  } state_e;

  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [CNT_W-1:0] instret_q;
  logic             halted_q;
  logic             retire;

  // Opcode dispatch out of DECODE.
  function automatic state_e decode_target(input logic [6:0] op);
    state_e target;
    case (op)
      OpLoad, OpStore: target = StMemAdr;
      OpReg:           target = StExR;
      OpImm:           target = StExI;
      OpBeq:           target = StBeq;
      OpJal:           target = StJal;
      OpJalr:          target = StJalr;
      OpLui:           target = StLui;
      default:         target = StIllegal;
    endcase
    return target;
  endfunction

  // Next-state logic; memory states hold until mem_ready.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch:   state_d = mem_ready ? StDecode : StFetch;
      StDecode:  state_d = decode_target(opcode);
      // opcode[5] separates store (1) from load (0).
      StMemAdr:  state_d = opcode[5] ? StMemWr : StMemRd;
      StMemRd:   state_d = mem_ready ? StMemWb : StMemRd;
      StMemWb:   state_d = StFetch;
      StMemWr:   state_d = mem_ready ? StFetch : StMemWr;
      StExR:     state_d = StAluWb;
      StExI:     state_d = StAluWb;
      StLui:     state_d = StAluWb;
      StAluWb:   state_d = StFetch;
      StBeq:     state_d = StFetch;
      StJal:     state_d = StFetch;
      StJalr:    state_d = StFetch;
      StIllegal: state_d = StIllegal;
      // Unused encodings recover to a clean fetch.
      default:   state_d = StFetch;
    endcase
  end

  // An instruction retires on the edge that leaves its last state for FETCH.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      StMemWb, StAluWb, StBeq, StJal, StJalr: retire = 1'b1;
      StMemWr:                                retire = mem_ready;
      default:                                retire = 1'b0;
    endcase
  end

  // State register, retired-instruction counter and sticky halt flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      instret_q <= '0;
      halted_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        instret_q <= instret_q + CntOne;
      end
      if (state_q == StIllegal) begin
        halted_q <= 1'b1;
      end
    end
  end

  // Moore output decode; only FETCH strobes depend on mem_ready, reset kills all.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    OldPCWrite  = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegWrite    = 1'b0;
    MemtoReg    = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    case (state_q)
      StFetch: begin
        // PC+4 goes straight into PC while OldPC keeps this instruction's PC.
        MemRead    = 1'b1;
        ALUSrcB    = 2'b01;
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        OldPCWrite = mem_ready;
      end
      StDecode: begin
        // Speculative branch/jump target OldPC + imm into ALUOut.
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      StMemRd: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      StMemWb: begin
        RegWrite = 1'b1;
        MemtoReg = 2'b01;
      end
      StMemWr: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      StExR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b10;
      end
      StLui: begin
        ALUSrcB = 2'b10;
        ALUOp   = 2'b11;
      end
      StAluWb: begin
        RegWrite = 1'b1;
      end
      StBeq: begin
        ALUSrcA     = 2'b10;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      StJal: begin
        // PC already holds PC+4 from FETCH, so it is the link value.
        PCWrite  = 1'b1;
        PCSource = 2'b01;
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      StJalr: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b10;
        PCWrite  = 1'b1;
        RegWrite = 1'b1;
        MemtoReg = 2'b10;
      end
      default: ;
    endcase
    if (reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      OldPCWrite  = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemtoReg    = 2'b00;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 2'b00;
      PCSource    = 2'b00;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;
  assign halted  = halted_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one task per scenario, inline checks.

module tb_multicycle_control;

  localparam int unsigned CNT_W = 32;

  logic             clk;
  logic             reset;
  logic [6:0]       opcode;
  logic             mem_ready;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             OldPCWrite;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegWrite;
  logic [1:0]       MemtoReg;
  logic [1:0]       ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;
  logic             halted;

  int               checks;
  int               errors;
  logic [CNT_W-1:0] exp_instret;

  wire [17:0] strobes = {PCWrite, PCWriteCond, OldPCWrite, IorD, MemRead, MemWrite, IRWrite,
                         RegWrite, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource};

  multicycle_control #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .opcode      (opcode),
    .mem_ready   (mem_ready),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .OldPCWrite  (OldPCWrite),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .RegWrite    (RegWrite),
    .MemtoReg    (MemtoReg),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .state       (state),
    .instret     (instret),
    .halted      (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 7'b0110011;
    tick();
    tick();
    checks++;
    if (state !== 4'd0) begin
      errors++; $display("FAIL reset_state got %0d want 0", state);
    end
    checks++;
    if (instret !== '0) begin
      errors++; $display("FAIL reset_instret got %0d want 0", instret);
    end
    checks++;
    if (halted !== 1'b0) begin
      errors++; $display("FAIL reset_halted got %0b want 0", halted);
    end
    checks++;
    if (strobes !== 18'd0) begin
      errors++; $display("FAIL reset_strobes got %h want 0", strobes);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({MemRead, IRWrite, PCWrite, OldPCWrite, IorD, ALUSrcB} !== 7'b1111001) begin
      errors++;
      $display("FAIL fetch_outputs got %b want 1111001",
               {MemRead, IRWrite, PCWrite, OldPCWrite, IorD, ALUSrcB});
    end
    mem_ready = 1'b0;
    #1;
    checks++;
    if ({MemRead, IRWrite, PCWrite, OldPCWrite} !== 4'b1000) begin
      errors++;
      $display("FAIL fetch_wait got %b want 1000", {MemRead, IRWrite, PCWrite, OldPCWrite});
    end
    mem_ready = 1'b1;
    #1;
  endtask

  task automatic test_rtype();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd6, 4'd8};
    opcode = 7'b0110011;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== exp_s[i]) begin
        errors++; $display("FAIL rtype_state[%0d] got %0d want %0d", i, state, exp_s[i]);
      end
      checks++;
      if (RegWrite !== (exp_s[i] == 4'd8)) begin
        errors++; $display("FAIL rtype_regwrite[%0d] got %0b", i, RegWrite);
      end
      if (exp_s[i] == 4'd6) begin
        checks++;
        if (ALUOp !== 2'b10 || ALUSrcA !== 2'b10 || ALUSrcB !== 2'b00) begin
          errors++;
          $display("FAIL rtype_exr got aluop %b srca %b srcb %b want 10 10 00",
                   ALUOp, ALUSrcA, ALUSrcB);
        end
      end
      tick();
    end
    exp_instret++;
    checks++;
    if (state !== 4'd0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL rtype_end got state %0d instret %0d want 0 %0d", state, instret, exp_instret);
    end
  endtask

  task automatic test_lw_wait();
    int held = 0;
    opcode = 7'b0000011;
    tick();
    tick();
    tick();
    checks++;
    if (state !== 4'd3) begin
      errors++; $display("FAIL lw_memrd_entry got %0d want 3", state);
    end
    mem_ready = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) begin
        mem_ready = 1'b1;
        #1;
      end
      if (state == 4'd3 && MemRead === 1'b1 && IorD === 1'b1) held++;
      tick();
    end
    checks++;
    if (held != 4) begin
      errors++; $display("FAIL lw_memread_held got %0d want 4", held);
    end
    checks++;
    if (state !== 4'd4 || RegWrite !== 1'b1 || MemtoReg !== 2'b01) begin
      errors++;
      $display("FAIL lw_memwb got state %0d regwrite %0b memtoreg %b want 4 1 01",
               state, RegWrite, MemtoReg);
    end
    tick();
    exp_instret++;
    checks++;
    if (state !== 4'd0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL lw_end got state %0d instret %0d want 0 %0d", state, instret, exp_instret);
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    int writes = 0;
    int regw   = 0;
    opcode = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== exp_s[i]) begin
        errors++; $display("FAIL sw_state[%0d] got %0d want %0d", i, state, exp_s[i]);
      end
      if (MemWrite === 1'b1) writes++;
      if (RegWrite === 1'b1) regw++;
      tick();
    end
    exp_instret++;
    checks++;
    if (writes != 1 || regw != 0) begin
      errors++; $display("FAIL sw_strobes got memwrite %0d regwrite %0d want 1 0", writes, regw);
    end
    checks++;
    if (state !== 4'd0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL sw_end got state %0d instret %0d want 0 %0d", state, instret, exp_instret);
    end
  endtask

  task automatic test_branch_jump();
    opcode = 7'b1100011;
    tick();
    tick();
    checks++;
    if (state !== 4'd9 || ALUOp !== 2'b01 || PCWriteCond !== 1'b1 || PCSource !== 2'b01
        || PCWrite !== 1'b0) begin
      errors++;
      $display("FAIL beq got state %0d aluop %b pcwc %0b pcsrc %b pcw %0b want 9 01 1 01 0",
               state, ALUOp, PCWriteCond, PCSource, PCWrite);
    end
    tick();
    opcode = 7'b1101111;
    tick();
    tick();
    checks++;
    if (state !== 4'd10 || PCWrite !== 1'b1 || PCSource !== 2'b01 || RegWrite !== 1'b1
        || MemtoReg !== 2'b10) begin
      errors++;
      $display("FAIL jal got state %0d pcw %0b pcsrc %b regw %0b memtoreg %b want 10 1 01 1 10",
               state, PCWrite, PCSource, RegWrite, MemtoReg);
    end
    tick();
    opcode = 7'b1100111;
    tick();
    tick();
    checks++;
    if (state !== 4'd11 || PCWrite !== 1'b1 || PCSource !== 2'b00 || ALUSrcA !== 2'b10
        || ALUSrcB !== 2'b10 || MemtoReg !== 2'b10) begin
      errors++;
      $display("FAIL jalr got state %0d pcw %0b pcsrc %b srca %b srcb %b memtoreg %b",
               state, PCWrite, PCSource, ALUSrcA, ALUSrcB, MemtoReg);
    end
    tick();
    opcode = 7'b0110111;
    tick();
    tick();
    checks++;
    if (state !== 4'd12 || ALUOp !== 2'b11 || ALUSrcB !== 2'b10 || RegWrite !== 1'b0) begin
      errors++;
      $display("FAIL lui got state %0d aluop %b srcb %b regw %0b want 12 11 10 0",
               state, ALUOp, ALUSrcB, RegWrite);
    end
    tick();
    tick();
    exp_instret += 4;
    checks++;
    if (state !== 4'd0 || instret !== exp_instret) begin
      errors++;
      $display("FAIL bj_end got state %0d instret %0d want 0 %0d", state, instret, exp_instret);
    end
  endtask

  task automatic test_illegal();
    int bad = 0;
    opcode = 7'b1111111;
    tick();
    tick();
    checks++;
    if (state !== 4'd15) begin
      errors++; $display("FAIL illegal_entry got %0d want 15", state);
    end
    for (int i = 0; i < 10; i++) begin
      if (strobes !== 18'd0 || state !== 4'd15 || instret !== exp_instret) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL illegal_quiet got %0d bad cycles want 0", bad);
    end
    checks++;
    if (halted !== 1'b1) begin
      errors++; $display("FAIL illegal_halted got %0b want 1", halted);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_instret = '0;
    #1;
    checks++;
    if (state !== 4'd0 || halted !== 1'b0 || instret !== '0) begin
      errors++;
      $display("FAIL illegal_reset got state %0d halted %0b instret %0d want 0 0 0",
               state, halted, instret);
    end
  endtask

  task automatic test_reset_memwr();
    // Retire one jal so the reset has a nonzero count to clear.
    opcode = 7'b1101111;
    tick();
    tick();
    tick();
    checks++;
    if (instret !== 32'd1) begin
      errors++; $display("FAIL pre_abort_instret got %0d want 1", instret);
    end
    opcode = 7'b0100011;
    tick();
    tick();
    tick();
    mem_ready = 1'b0;
    #1;
    tick();
    checks++;
    if (state !== 4'd5 || MemWrite !== 1'b1) begin
      errors++;
      $display("FAIL memwr_wait got state %0d memwrite %0b want 5 1", state, MemWrite);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (MemWrite !== 1'b0 || strobes !== 18'd0) begin
      errors++;
      $display("FAIL abort_strobes got memwrite %0b strobes %h want 0 0", MemWrite, strobes);
    end
    tick();
    checks++;
    if (state !== 4'd0 || instret !== '0 || MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL abort_state got state %0d instret %0d memwrite %0b want 0 0 0",
               state, instret, MemWrite);
    end
    reset     = 1'b0;
    mem_ready = 1'b1;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    exp_instret = '0;
    reset       = 1'b1;
    mem_ready   = 1'b0;
    opcode      = 7'd0;
    test_reset();
    test_rtype();
    test_lw_wait();
    test_sw();
    test_branch_jump();
    test_illegal();
    test_reset_memwr();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
